load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage initiator that drives the word-indexed data memory: write enable, address, write data, and combinational read data.
- Accepts one RV32I load/store request at a time from the pipeline.
- Performs byte/halfword accesses by extracting lanes on loads and by read-modify-write on sub-word stores.
- Sign- or zero-extends load data, flags misaligned, out-of-range and illegal requests, and holds off the pipeline through req_ready.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached memory; word index must be < DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_misaligned  output  1  valid with resp_valid: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- resp_fault  output  1  valid with resp_valid: word index >= DEPTH, or illegal funct3.
- mem_we  output  1  memory write enable, sampled by memory at posedge clk.
- mem_addr  output  32  word index = {2'b00, addr[31:2]}.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational memory read of mem_addr.

Behaviour:
- States: IDLE, ACCESS, MERGE, RESP. State, latched request (write, funct3, addr, wdata), captured word, and response regs are all reset asynchronously when rst=0.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_misaligned=0; resp_fault=0; mem_we=0; mem_addr=0; mem_wdata=0.
- mem_we is decoded from state only, so it drops within the same cycle rst asserts. Reset mid-operation abandons the request, and no write occurs after rst asserts.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Error check (misaligned, out-of-range, or illegal funct3) → RESP with the error flag set. No memory access; mem_we stays 0 throughout.
  - Otherwise → ACCESS.
- ACCESS: req_ready=0; mem_addr = latched word index.
  - Load: capture mem_rdata, extract and extend the lane, → RESP.
  - SW: mem_we=1, mem_wdata=latched wdata, → RESP.
  - SB/SH: capture mem_rdata into merge register, mem_we=0, → MERGE.
- MERGE: mem_we=1; mem_wdata = captured word with byte lane addr[1:0] (SB) or halfword lane addr[1] replaced by wdata[7:0] / wdata[15:0]; other lanes unchanged. → RESP.
- RESP: resp_valid=1 for exactly one cycle; response outputs hold their values until the next RESP. req_ready=0. → IDLE.
- Load extraction: byte lane = addr[1:0], halfword lane = addr[1]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency from the accepting edge to the resp_valid cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Throughput: one request per 3 cycles (loads and SW) or 4 cycles (SB/SH).
- req_valid while req_ready=0 is ignored; the requester holds the request until accepted.
- Inputs change while busy: no effect; only latched values are used.
- Outside ACCESS/MERGE: mem_addr holds the last latched index and mem_we=0.

Test Plan:
- Load lanes: preload word 4 = 0x80F07F01. Results:
  - LB 0x10 → 0x00000001.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80F0.
  - LHU 0x12 → 0x000080F0.
  - LW 0x10 → 0x80F07F01.
  - Each resp_valid arrives 2 cycles after accept; no mem_we.
- Sub-word stores on word 4 = 0x80F07F01:
  - SB 0x11 data 0x123456AA → word 4 = 0x80F0AA01, 3-cycle latency, mem_we high exactly one cycle (MERGE).
  - Then SH 0x12 data 0xBEEF → 0xBEEFAA01.
- SW 0x20 data 0xDEADBEEF → word 8 = 0xDEADBEEF, 2-cycle latency. Following LW 0x20 returns the same value.
- Errors, each with 1-cycle latency and memory unchanged:
  - SH 0x11 → resp_misaligned=1, no mem_we.
  - LW 0x1002 → resp_misaligned=1.
  - LW 0x1000 (index 1024, DEPTH=1024) → resp_fault=1, resp_rdata=0.
  - Load funct3=011 → resp_fault=1.
- Handshake: hold req_valid high across back-to-back LW 0x0 and LW 0x4.
  - req_ready low for 2 cycles after each accept.
  - Exactly two resp_valid pulses, 3 cycles apart.
- Reset mid-SB: drop rst during MERGE.
  - mem_we falls immediately and the target word is unchanged.
  - All outputs reach reset values; after release, req_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for RV32I: drives a word-indexed data memory,
// extracts/extends load lanes and performs read-modify-write for SB/SH.
module load_store_unit #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;

  logic [31:0] reqIdx;
  logic        reqMis, reqIllegal, reqFault;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadExt;
  logic [31:0] merged;

  // Errors are decided on the incoming request so they can answer one cycle after accept.
  always_comb begin
    reqIdx     = {2'b00, req_addr[31:2]};
    reqMis     = 1'b0;
    reqIllegal = 1'b0;
    case (req_funct3)
      3'b000:  reqIllegal = 1'b0;
      3'b100:  reqIllegal = req_write;
      3'b001:  reqMis = req_addr[0];
      3'b101: begin
        reqIllegal = req_write;
        reqMis     = !req_write && req_addr[0];
      end
      3'b010:  reqMis = |req_addr[1:0];
      default: reqIllegal = 1'b1;
    endcase
    reqFault = reqIllegal || (reqIdx >= DEPTH);
  end

  always_comb begin
    laneByte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    laneHalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
      3'b010:  loadExt = mem_rdata;
      3'b100:  loadExt = {24'h0, laneByte};
      3'b101:  loadExt = {16'h0, laneHalf};
      default: loadExt = 32'h0;
    endcase
  end

  // funct3[0] distinguishes SH from SB; only those two reach MERGE.
  always_comb begin
    merged = word_q;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (reqMis || reqFault) begin
            state_d = RESP;
            rdata_d = 32'h0;
            mis_d   = reqMis;
            fault_d = reqFault;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q || funct3_q == 3'b010) begin
          state_d = RESP;
          rdata_d = write_q ? 32'h0 : loadExt;
          mis_d   = 1'b0;
          fault_d = 1'b0;
        end else begin
          word_d  = mem_rdata;
          state_d = MERGE;
        end
      end
      MERGE: begin
        state_d = RESP;
        rdata_d = 32'h0;
        mis_d   = 1'b0;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      fault_q  <= fault_d;
    end
  end

  // Write enable comes straight from state so an asserted reset kills it at once.
  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    resp_rdata      = rdata_q;
    resp_misaligned = mis_q;
    resp_fault      = fault_q;
    mem_addr        = {2'b00, addr_q[31:2]};
    mem_we          = 1'b0;
    mem_wdata       = 32'h0;
    if (state_q == MERGE) begin
      mem_we    = 1'b1;
      mem_wdata = merged;
    end else if (state_q == ACCESS && write_q && funct3_q == 3'b010) begin
      mem_we    = 1'b1;
      mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with an attached behavioural memory
// and a scoreboard of expected responses.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          lat;
    int          we;
  } vec_t;

  vec_t        sbq[$];
  int          checks;
  int          failures;
  logic [31:0] mem [0:1023];
  logic        pokeEn;
  logic [9:0]  pokeIdx;
  logic [31:0] pokeData;
  int          gotLat;
  int          gotWe;
  logic [31:0] gotRdata;
  logic        gotMis;
  logic        gotFault;

  load_store_unit #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on posedge.
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    else if (pokeEn) mem[pokeIdx] <= pokeData;
  end

  task automatic poke(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pokeEn = 1'b1; pokeIdx = idx; pokeData = data;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Drives one request, then records latency, write-enable cycles and the response.
  task automatic issue(input vec_t v);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
    gotLat = -1; gotWe = 0; gotRdata = 32'hX; gotMis = 1'bX; gotFault = 1'bX;
    for (int k = 1; k <= 10; k++) begin
      if (mem_we) gotWe++;
      if (resp_valid) begin
        gotLat = k; gotRdata = resp_rdata; gotMis = resp_misaligned; gotFault = resp_fault;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pokeEn = 1'b0; pokeIdx = 10'h0; pokeData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault, mem_we, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_values: got ready=%b rv=%b rdata=%h mis=%b flt=%b we=%b addr=%h wd=%h, expected 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_loads;
    vec_t v[6];
    vec_t e;
    v[0] = '{"LB_0x10",  1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 2, 0};
    v[1] = '{"LB_0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 0};
    v[2] = '{"LBU_0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 2, 0};
    v[3] = '{"LH_0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80F0, 1'b0, 1'b0, 2, 0};
    v[4] = '{"LHU_0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_80F0, 1'b0, 1'b0, 2, 0};
    v[5] = '{"LW_0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80F0_7F01, 1'b0, 1'b0, 2, 0};
    poke(10'd4, 32'h80F0_7F01);
    foreach (v[i]) begin
      sbq.push_back(v[i]);
      issue(v[i]);
      e = sbq.pop_front();
      checks++;
      if (gotLat !== e.lat) begin failures++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.name, gotLat, e.lat); end
      checks++;
      if (gotRdata !== e.rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", e.name, gotRdata, e.rdata); end
      checks++;
      if ({gotMis, gotFault} !== {e.mis, e.fault}) begin failures++; $display("[TB] FAIL %s flags: got %b%b expected %b%b", e.name, gotMis, gotFault, e.mis, e.fault); end
      checks++;
      if (gotWe !== e.we) begin failures++; $display("[TB] FAIL %s we_cycles: got %0d expected %0d", e.name, gotWe, e.we); end
    end
  endtask

  task automatic test_stores;
    vec_t v[4];
    vec_t e;
    logic [31:0] memAfter[4];
    int          memIdx[4];
    v[0] = '{"SB_0x11", 1'b1, 3'b000, 32'h11, 32'h1234_56AA, 32'h0, 1'b0, 1'b0, 3, 1};
    v[1] = '{"SH_0x12", 1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 3, 1};
    v[2] = '{"SW_0x20", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 2, 1};
    v[3] = '{"LW_0x20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 0};
    memIdx[0] = 4; memAfter[0] = 32'h80F0_AA01;
    memIdx[1] = 4; memAfter[1] = 32'hBEEF_AA01;
    memIdx[2] = 8; memAfter[2] = 32'hDEAD_BEEF;
    memIdx[3] = 8; memAfter[3] = 32'hDEAD_BEEF;
    foreach (v[i]) begin
      sbq.push_back(v[i]);
      issue(v[i]);
      e = sbq.pop_front();
      checks++;
      if (gotLat !== e.lat) begin failures++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.name, gotLat, e.lat); end
      checks++;
      if (gotRdata !== e.rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", e.name, gotRdata, e.rdata); end
      checks++;
      if (gotWe !== e.we) begin failures++; $display("[TB] FAIL %s we_cycles: got %0d expected %0d", e.name, gotWe, e.we); end
      checks++;
      if (mem[memIdx[i]] !== memAfter[i]) begin failures++; $display("[TB] FAIL %s memory: got %h expected %h", e.name, mem[memIdx[i]], memAfter[i]); end
    end
  endtask

  task automatic test_errors;
    vec_t v[4];
    vec_t e;
    v[0] = '{"SH_0x11_misaligned", 1'b1, 3'b001, 32'h11,   32'h0000_1234, 32'h0, 1'b1, 1'b0, 1, 0};
    v[1] = '{"LW_0x1002",          1'b0, 3'b010, 32'h1002, 32'h0,         32'h0, 1'b1, 1'b1, 1, 0};
    v[2] = '{"LW_0x1000_range",    1'b0, 3'b010, 32'h1000, 32'h0,         32'h0, 1'b0, 1'b1, 1, 0};
    v[3] = '{"LOAD_f3_011",        1'b0, 3'b011, 32'h10,   32'h0,         32'h0, 1'b0, 1'b1, 1, 0};
    foreach (v[i]) begin
      sbq.push_back(v[i]);
      issue(v[i]);
      e = sbq.pop_front();
      checks++;
      if (gotLat !== e.lat) begin failures++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.name, gotLat, e.lat); end
      checks++;
      if (gotRdata !== e.rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", e.name, gotRdata, e.rdata); end
      checks++;
      if ({gotMis, gotFault} !== {e.mis, e.fault}) begin failures++; $display("[TB] FAIL %s flags: got %b%b expected %b%b", e.name, gotMis, gotFault, e.mis, e.fault); end
      checks++;
      if (gotWe !== e.we) begin failures++; $display("[TB] FAIL %s we_cycles: got %0d expected %0d", e.name, gotWe, e.we); end
    end
    checks++;
    if (mem[4] !== 32'hBEEF_AA01) begin failures++; $display("[TB] FAIL errors_mem_unchanged: got %h expected %h", mem[4], 32'hBEEF_AA01); end
  endtask

  task automatic test_back_to_back;
    vec_t e;
    vec_t a, b;
    logic [6:0] readyVec, respVec;
    a = '{"B2B_LW_0x0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 2, 0};
    b = '{"B2B_LW_0x4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h2222_2222, 1'b0, 1'b0, 2, 0};
    poke(10'd0, 32'h1111_1111);
    poke(10'd1, 32'h2222_2222);
    sbq.push_back(a);
    sbq.push_back(b);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    @(posedge clk);
    #1;
    req_addr = 32'h4;
    for (int s = 1; s <= 7; s++) begin
      readyVec[s-1] = req_ready;
      respVec[s-1]  = resp_valid;
      if (resp_valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (resp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", e.name, resp_rdata, e.rdata); end
      end
      if (s == 4) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (readyVec !== 7'b1100100) begin failures++; $display("[TB] FAIL b2b_ready_pattern: got %b expected %b", readyVec, 7'b1100100); end
    checks++;
    if (respVec !== 7'b0010010) begin failures++; $display("[TB] FAIL b2b_resp_pattern: got %b expected %b", respVec, 7'b0010010); end
    checks++;
    if (sbq.size() !== 0) begin failures++; $display("[TB] FAIL b2b_scoreboard_drained: got %0d expected 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_reset_mid_store;
    vec_t v;
    vec_t e;
    poke(10'd12, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL rst_merge_reached: got mem_we=%b expected 1", mem_we); end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_we_drop: got %b expected 0", mem_we); end
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rst_mid_outputs: got ready=%b rv=%b rdata=%h mis=%b flt=%b addr=%h wd=%h, expected 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[12] !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL rst_mem_unchanged: got %h expected %h", mem[12], 32'hCAFE_F00D); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready: got %b expected 1", req_ready); end
    v = '{"POST_RST_LW_0x30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 0};
    sbq.push_back(v);
    issue(v);
    e = sbq.pop_front();
    checks++;
    if (gotLat !== e.lat) begin failures++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.name, gotLat, e.lat); end
    checks++;
    if (gotRdata !== e.rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", e.name, gotRdata, e.rdata); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_store();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
